// File: rtl/lab_buffer_ctrl.sv
// LAB sample buffer controller: queues digitize requests, captures the streamed
// sample words into one of four RAM buffers, and serves synchronous reads to the local bus.
module lab_buffer_ctrl #(
  parameter int unsigned WORDS_LOG2 = 11,
  parameter int unsigned TIMEOUT    = 4095
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_all_i,
  input  logic [3:0]            digitize_i,
  output logic                  dig_start_o,
  output logic [1:0]            dig_buf_o,
  input  logic                  wr_valid_i,
  input  logic [31:0]           wr_dat_i,
  input  logic [WORDS_LOG2+1:0] rd_addr_i,
  output logic [31:0]           rd_dat_o,
  input  logic                  release_i,
  output logic                  lab_ready_o,
  output logic [3:0]            done_o,
  output logic                  busy_o,
  output logic                  overflow_o,
  output logic                  timeout_o
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
  localparam int unsigned DEPTH  = 4 << WORDS_LOG2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            pending_q, pending_d;
  logic [3:0]            done_q, done_d;
  logic                  dig_start_q, dig_start_d;
  logic [1:0]            dig_buf_q, dig_buf_d;
  logic                  busy_q, busy_d;
  logic                  overflow_q, overflow_d;
  logic                  timeout_q, timeout_d;
  logic [WORDS_LOG2-1:0] wcnt_q, wcnt_d;
  logic [IDLE_W-1:0]     idle_q, idle_d;
  logic                  ram_we;
  logic [1:0]            rd_buf;
  logic [1:0]            pick;
  logic [31:0]           rd_dat_q;

  logic [31:0] mem [DEPTH];

  assign rd_buf = rd_addr_i[WORDS_LOG2+1 -: 2];

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block can infer a latch.
    state_d     = state_q;
    pending_d   = pending_q;
    done_d      = done_q;
    dig_start_d = 1'b0;
    dig_buf_d   = dig_buf_q;
    busy_d      = busy_q;
    overflow_d  = overflow_q;
    timeout_d   = timeout_q;
    wcnt_d      = wcnt_q;
    idle_d      = idle_q;
    ram_we      = 1'b0;
    pick        = 2'd0;

    // Intake judges against the registered flags, i.e. before this cycle's release.
    for (int n = 0; n < 4; n++) begin
      if (digitize_i[n]) begin
        if (pending_q[n] || done_q[n] || (busy_q && dig_buf_q == 2'(n))) overflow_d = 1'b1;
        else                                                               pending_d[n] = 1'b1;
      end
    end

    for (int n = 3; n >= 0; n--) begin
      if (pending_q[n]) pick = 2'(n);
    end

    if (release_i) done_d[rd_buf] = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pending_q != 4'd0) begin
          pending_d[pick] = 1'b0;
          dig_buf_d       = pick;
          dig_start_d     = 1'b1;
          busy_d          = 1'b1;
          state_d         = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (wr_valid_i) begin
          ram_we = 1'b1;
          wcnt_d = wcnt_q + 1'b1;
          idle_d = '0;
          if (wcnt_q == '1) state_d = ST_DONE;
        end else if (idle_q >= IDLE_W'(TIMEOUT - 1)) begin
          idle_d    = IDLE_W'(TIMEOUT);
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      ST_DONE: begin
        // Applied after the release clear so a coincident release loses.
        done_d[dig_buf_q] = 1'b1;
        wcnt_d            = '0;
        idle_d            = '0;
        busy_d            = 1'b0;
        state_d           = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      done_q      <= '0;
      dig_start_q <= 1'b0;
      dig_buf_q   <= '0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
      wcnt_q      <= '0;
      idle_q      <= '0;
    end else if (clr_all_i) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      done_q      <= '0;
      dig_start_q <= 1'b0;
      dig_buf_q   <= '0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
      wcnt_q      <= '0;
      idle_q      <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      done_q      <= done_d;
      dig_start_q <= dig_start_d;
      dig_buf_q   <= dig_buf_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
      timeout_q   <= timeout_d;
      wcnt_q      <= wcnt_d;
      idle_q      <= idle_d;
    end
  end

  // NOTE: the sample RAM has no reset so it maps onto block RAM; stale words are expected after an aborted capture.
  always_ff @(posedge clk_i) begin
    if (ram_we && !clr_all_i) mem[{dig_buf_q, wcnt_q}] <= wr_dat_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rd_dat_q <= '0;
    else       rd_dat_q <= mem[rd_addr_i];
  end

  assign dig_start_o = dig_start_q;
  assign dig_buf_o   = dig_buf_q;
  assign rd_dat_o    = rd_dat_q;
  assign lab_ready_o = done_q[rd_buf];
  assign done_o      = done_q;
  assign busy_o      = busy_q;
  assign overflow_o  = overflow_q;
  assign timeout_o   = timeout_q;

endmodule
